// File: rtl/dmem_pkg.sv
// Shared types and helpers for the sized-access RV32 data memory.
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic {
        ST_INIT,
        ST_READY
    } state_e;

    function automatic logic is_misaligned(
        input logic [1:0] size,
        input logic [1:0] off
    );
        return ((size == SZ_HALF) && off[0]) ||
               ((size == SZ_WORD) && (off != 2'b00));
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering: store mask/replication and load extract/extend.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [1:0]  off_i,
    input  logic        uns_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rword_i,
    output logic [3:0]  wmask_o,
    output logic [31:0] wrep_o,
    output logic [31:0] rdata_o
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    assign ld_byte = rword_i[{off_i, 3'b000} +: 8];
    assign ld_half = off_i[1] ? rword_i[31:16] : rword_i[15:0];

    always_comb begin
        wmask_o = 4'b0000;
        wrep_o  = wdata_i;
        rdata_o = '0;
        case (size_i)
            SZ_BYTE: begin
                wmask_o = 4'b0001 << off_i;
                wrep_o  = {4{wdata_i[7:0]}};
                rdata_o = {{24{~uns_i & ld_byte[7]}}, ld_byte};
            end
            SZ_HALF: begin
                wmask_o = off_i[1] ? 4'b1100 : 4'b0011;
                wrep_o  = {2{wdata_i[15:0]}};
                rdata_o = {{16{~uns_i & ld_half[15]}}, ld_half};
            end
            SZ_WORD: begin
                wmask_o = 4'b1111;
                rdata_o = rword_i;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dmem_sized_access.sv
// RV32 data memory: sized byte-addressed access, 1-cycle registered
// response, fault flagging and a sequential clear after reset.
module dmem_sized_access
    import dmem_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_fault,
    output logic              init_busy
);

    localparam int IW  = ADDR_W - 2;
    localparam int IWP = IW + 1;
    localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IW:0]   DEPTH_C = IWP'(DEPTH);
    localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

    logic [31:0]   mem_q [DEPTH];
    state_e        state_q;
    logic [AW-1:0] clr_idx_q;

    logic          rsp_valid_q, rsp_valid_d;
    logic          rsp_fault_q, rsp_fault_d;
    logic [31:0]   rsp_rdata_q, rsp_rdata_d;

    logic [IW-1:0] widx;
    logic [AW-1:0] aidx;
    logic [1:0]    off;
    logic          in_range;
    logic          fault;
    logic          accept;
    logic [31:0]   rword;
    logic [3:0]    wmask;
    logic [31:0]   wrep;
    logic [31:0]   ld_data;

    assign widx     = req_addr[ADDR_W-1:2];
    assign off      = req_addr[1:0];
    assign aidx     = widx[AW-1:0];
    assign in_range = {1'b0, widx} < DEPTH_C;
    assign fault    = (req_size == 2'b11) |
                      is_misaligned(req_size, off) |
                      ~in_range;
    assign rword    = in_range ? mem_q[aidx] : '0;

    assign req_ready = (state_q == ST_READY) & ~reset;
    assign init_busy = (state_q == ST_INIT);
    assign accept    = req_valid & req_ready;

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_fault = rsp_fault_q;

    dmem_lane_align u_align (
        .size_i  (req_size),
        .off_i   (off),
        .uns_i   (req_unsigned),
        .wdata_i (req_wdata),
        .rword_i (rword),
        .wmask_o (wmask),
        .wrep_o  (wrep),
        .rdata_o (ld_data)
    );

    always_comb begin
        rsp_valid_d = accept;
        rsp_fault_d = rsp_fault_q;
        rsp_rdata_d = rsp_rdata_q;
        if (accept) begin
            rsp_fault_d = fault;
            rsp_rdata_d = (fault | req_we) ? '0 : ld_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_INIT;
            clr_idx_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_fault_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_fault_q <= rsp_fault_d;
            rsp_rdata_q <= rsp_rdata_d;
            if (state_q == ST_INIT) begin
                clr_idx_q <= clr_idx_q + 1'b1;
                if (clr_idx_q == LAST) begin
                    state_q <= ST_READY;
                end
            end
        end
    end

    // Array has no reset; the INIT walk clears it one word per cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state_q == ST_INIT) begin
                mem_q[clr_idx_q] <= '0;
            end else if (accept & req_we & ~fault) begin
                for (int i = 0; i < 4; i++) begin
                    if (wmask[i]) begin
                        mem_q[aidx][8*i +: 8] <= wrep[8*i +: 8];
                    end
                end
            end
        end
    end

endmodule
